clause_sched_ctrl: RTL and testbench

Sequencer for the 8-PE convolution clause unit. For each of CLAUSEN clauses per image it:
- fetches the clause word from clause memory,
- loads it into the clause unit,
- sweeps every patch position (x serially, 8 y-rows in parallel across the PEs),
- waits out the pipeline latency,
- captures the clause output into a result vector.
It sits between the top-level image controller and the clause unit / clause memory.

---
 rtl/clause_sched_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_clause_sched_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_sched_ctrl.sv
// clause_sched_ctrl: per-image sequencer for the 8-PE convolution clause unit.
// For every clause it fetches the clause word, loads it, sweeps all patch
// positions (x serially, 8 y-rows in parallel), drains the pipeline and
// captures the OR-reduced clause output into clause_vec.
// Optional build macro: CLAUSE_SKIP_EN -- an all-zero clause word skips RUN
// and DRAIN and stores a 0 for that clause.
module clause_sched_ctrl #(
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32,
  parameter int unsigned CLAUSEN    = 10,
  parameter int unsigned CLAUSE_W   = 256,
  parameter int unsigned LAT        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [2:0]                   patch_size,
  input  logic [2:0]                   stride,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  output logic                         mem_req,
  output logic [$clog2(CLAUSEN)-1:0]   mem_addr,
  input  logic                         mem_ack,
  input  logic [CLAUSE_W-1:0]          mem_data,
  output logic [CLAUSE_W-1:0]          clause_write,
  output logic                         valid,
  output logic                         img_rst,
  output logic                         clause_act,
  output logic [7:0]                   pe_en,
  output logic [7:0]                   x_pos,
  output logic [7:0]                   y_base,
  input  logic                         clause_op_in,
  output logic [CLAUSEN-1:0]           clause_vec
);

  localparam int unsigned AW  = $clog2(CLAUSEN);
  localparam int unsigned PW  = 9;   // position register width
  localparam int unsigned CW  = 10;  // compare width, one guard bit over PW
  localparam int unsigned LCW = 4;   // drain counter width (LAT <= 15)

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_STORE,
    S_FIN
  } state_e;

  state_e                state_q;
  logic [2:0]            p_q;
  logic [2:0]            s_q;
  logic [AW-1:0]         idx_q;
  logic [LCW-1:0]        cnt_q;
  logic [PW-1:0]         x_q;
  logic [PW-1:0]         y_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  cfg_err_q;
  logic                  mem_req_q;
  logic [CLAUSE_W-1:0]   word_q;
  logic                  valid_q;
  logic                  img_rst_q;
  logic                  act_q;
  logic [7:0]            pe_q;
  logic [CLAUSEN-1:0]    vec_q;

  logic [PW-1:0]         x_d;
  logic [PW-1:0]         y_d;
  logic [7:0]            pe_d;
  logic [7:0]            pe_first_c;
  logic                  run_last_c;
  logic                  cfg_ok_c;
  logic                  skip_c;
  logic                  word_zero_c;
  logic [CW-1:0]         x_step_c;
  logic [CW-1:0]         y_step_c;

  // Row-enable mask for a PE group whose first row sits at y.
  function automatic logic [7:0] pe_mask(input logic [PW-1:0] y,
                                         input logic [2:0]    s,
                                         input logic [2:0]    p);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      m[k] = (CW'(y) + CW'(k) * CW'(s) + CW'(p)) <= CW'(IMG_HEIGHT);
    end
    return m;
  endfunction

  // Start-time configuration legality.
  always_comb begin
    cfg_ok_c = ((patch_size == 3'd3) || (patch_size == 3'd5) ||
                (patch_size == 3'd7)) &&
               (stride >= 3'd1) && (stride <= 3'd4);
  end

  // Empty-clause detection on the incoming and on the held clause word.
  always_comb begin
    word_zero_c = 1'b0;
    skip_c      = 1'b0;
`ifdef CLAUSE_SKIP_EN
    word_zero_c = (mem_data == '0);
    skip_c      = (word_q == '0);
`endif
  end

  // Next sweep position: step x by stride, or wrap x and move to the next 8-row group.
  always_comb begin
    x_step_c   = CW'(x_q) + CW'(s_q) + CW'(p_q);
    y_step_c   = CW'(y_q) + CW'({s_q, 3'b000});
    run_last_c = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    if (x_step_c <= CW'(IMG_WIDTH)) begin
      x_d = PW'(CW'(x_q) + CW'(s_q));
    end else begin
      x_d        = '0;
      y_d        = y_step_c[PW-1:0];
      run_last_c = (y_step_c + CW'(p_q)) > CW'(IMG_HEIGHT);
    end
    pe_d       = pe_mask(y_d, s_q, p_q);
    pe_first_c = pe_mask('0, s_q, p_q);
  end

  // Sequencer state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      s_q       <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      mem_req_q <= 1'b0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      img_rst_q <= 1'b0;
      act_q     <= 1'b0;
      pe_q      <= '0;
      vec_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      valid_q   <= 1'b0;
      img_rst_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok_c) begin
              p_q       <= patch_size;
              s_q       <= stride;
              idx_q     <= '0;
              vec_q     <= '0;
              busy_q    <= 1'b1;
              mem_req_q <= 1'b1;
              state_q   <= S_FETCH;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            word_q    <= mem_data;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b1;
            img_rst_q <= 1'b1;
            act_q     <= ~word_zero_c;
            x_q       <= '0;
            y_q       <= '0;
            pe_q      <= '0;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (skip_c) begin
            state_q <= S_STORE;
          end else begin
            pe_q    <= pe_first_c;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (run_last_c) begin
            pe_q    <= '0;
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            pe_q <= pe_d;
          end
        end
        S_DRAIN: begin
          if (cnt_q == LCW'(LAT - 1)) begin
            act_q   <= 1'b0;
            state_q <= S_STORE;
          end else begin
            cnt_q <= cnt_q + LCW'(1);
          end
        end
        S_STORE: begin
          vec_q[idx_q] <= clause_op_in & ~skip_c;
          if (idx_q == AW'(CLAUSEN - 1)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FIN;
          end else begin
            idx_q     <= idx_q + AW'(1);
            mem_req_q <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = idx_q;
  assign clause_write = word_q;
  assign valid        = valid_q;
  assign img_rst      = img_rst_q;
  assign clause_act   = act_q;
  assign pe_en        = pe_q;
  assign x_pos        = x_q[7:0];
  assign y_base       = y_q[7:0];
  assign clause_vec   = vec_q;

endmodule

// File: tb/tb_clause_sched_ctrl.sv
// tb_clause_sched_ctrl: randomized bench for clause_sched_ctrl against a
// position-list reference model derived from NX/NY/NG patch geometry.
module tb_clause_sched_ctrl;

  localparam int unsigned W   = 32;
  localparam int unsigned H   = 32;
  localparam int unsigned CN  = 10;
  localparam int unsigned CW  = 256;
  localparam int unsigned LAT = 4;
  localparam int unsigned BUDGET = 5000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      patch_size = 3'd3;
  logic [2:0]      stride = 3'd1;
  logic            busy, done, cfg_err, mem_req;
  logic [3:0]      mem_addr;
  logic            mem_ack = 1'b0;
  logic [CW-1:0]   mem_data = '0;
  logic [CW-1:0]   clause_write;
  logic            valid, img_rst, clause_act;
  logic [7:0]      pe_en, x_pos, y_base;
  logic            clause_op_in = 1'b0;
  logic [CN-1:0]   clause_vec;

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] words [CN];
  logic [23:0]   posq [$];
  bit            skip_zero;
  bit            aborted;

  always #5 clk = ~clk;

  clause_sched_ctrl #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .CLAUSEN   (CN),
    .CLAUSE_W  (CW),
    .LAT       (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .patch_size  (patch_size),
    .stride      (stride),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .clause_write(clause_write),
    .valid       (valid),
    .img_rst     (img_rst),
    .clause_act  (clause_act),
    .pe_en       (pe_en),
    .x_pos       (x_pos),
    .y_base      (y_base),
    .clause_op_in(clause_op_in),
    .clause_vec  (clause_vec)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] ctl_outs();
    return {clause_vec, y_base, x_pos, pe_en, clause_act, img_rst, valid,
            mem_addr, mem_req, cfg_err, done, busy};
  endfunction

  // Expected RUN positions for one clause: NG groups of 8 rows, NX x origins each.
  function automatic void build_positions(input int p, input int s);
    int nx, ny, ng;
    logic [23:0] e;
    posq.delete();
    nx = (W - p) / s + 1;
    ny = (H - p) / s + 1;
    ng = (ny + 7) / 8;
    for (int g = 0; g < ng; g++) begin
      for (int i = 0; i < nx; i++) begin
        e[23:16] = 8'(i * s);
        e[15:8]  = 8'(8 * g * s);
        for (int k = 0; k < 8; k++) e[k] = ((8 * g + k) < ny);
        posq.push_back(e);
      end
    end
  endfunction

  // One image: start, serve memory, follow every position, check the result at done.
  task automatic run_image(input int p, input int s, input int ack_max,
                           input logic [CN-1:0] op_mask, input logic [CN-1:0] zero_mask,
                           input int abort_clause, input bit poke);
    int cur = -1;
    int next_addr = 0;
    int ack_wait = -1;
    int nvalid = 0;
    int act_cnt = 0;
    int exp_act = 0;
    int cyc = 0;
    int per_clause;
    bit fin = 0;
    logic [CN-1:0] exp_vec;
    logic [23:0] e;

    for (int i = 0; i < CN; i++) begin
      for (int j = 0; j < 8; j++) words[i][32*j +: 32] = $urandom;
      if (zero_mask[i]) words[i] = '0;
    end
    per_clause = 1 + ((W - p) / s + 1) * ((((H - p) / s + 1) + 7) / 8) + LAT;
    for (int i = 0; i < CN; i++) exp_act += (skip_zero && zero_mask[i]) ? 0 : per_clause;
    exp_vec = op_mask & ~(skip_zero ? zero_mask : '0);
    posq.delete();
    aborted = 0;

    patch_size = 3'(p);
    stride     = 3'(s);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    patch_size = 3'($urandom);
    stride     = 3'($urandom);

    while (!fin) begin
      start = poke && busy && (cyc == 40);
      if (mem_ack) mem_ack = 1'b0;
      if (mem_req && ack_wait < 0) begin
        check_eq("addr", 256'(mem_addr), 256'(next_addr));
        ack_wait = $urandom_range(ack_max, 0);
      end
      if (ack_wait == 0) begin
        mem_ack  = 1'b1;
        mem_data = (next_addr < CN) ? words[next_addr] : '0;
        cur      = next_addr;
        next_addr++;
        ack_wait = -1;
      end else if (ack_wait > 0) begin
        ack_wait--;
      end
      if (valid || img_rst) begin
        check_eq("load_pulse", {valid, img_rst}, 2'b11);
        check_eq("wr", clause_write, (cur >= 0 && cur < CN) ? words[cur] : '0);
        check_eq("run_short", 256'(posq.size()), 0);
        nvalid++;
        if (!(skip_zero && cur >= 0 && cur < CN && zero_mask[cur])) build_positions(p, s);
        else posq.delete();
      end
      if (pe_en != 8'h00) begin
        if (posq.size() == 0) begin
          check_eq("run_extra", {x_pos, y_base, pe_en}, 0);
        end else begin
          e = posq.pop_front();
          check_eq("pos", {x_pos, y_base, pe_en}, e);
          if (abort_clause >= 0 && cur == abort_clause) begin
            #2 rst = 1'b1;
            #1;
            check_eq("rst_outs", ctl_outs(), 0);
            check_eq("rst_word", clause_write, 0);
            start = 1'b0;
            mem_ack = 1'b0;
            clause_op_in = 1'b0;
            aborted = 1;
            return;
          end
        end
      end
      if (clause_act) act_cnt++;
      if (cfg_err) check_eq("cfg_busy", cfg_err, 0);
      if (done) begin
        check_eq("busy_at_done", busy, 0);
        check_eq("vec", clause_vec, exp_vec);
        check_eq("nvalid", 256'(nvalid), 256'(CN));
        check_eq("act_cycles", 256'(act_cnt), 256'(exp_act));
        check_eq("run_left", 256'(posq.size()), 0);
        fin = 1;
      end
      clause_op_in = (cur >= 0 && cur < CN) ? op_mask[cur] : 1'b0;
      cyc++;
      if (!fin && cyc > BUDGET) begin
        check_eq("timeout", 1, 0);
        fin = 1;
      end
      if (!fin) tick();
    end
    start = 1'b0;
    mem_ack = 1'b0;
    clause_op_in = 1'b0;
    tick();
    check_eq("done_pulse", {done, busy}, 2'b00);
    check_eq("vec_hold", clause_vec, exp_vec);
  endtask

  initial begin
    int p, s;
    int pv[3];
    logic [2:0] ip [6];
    logic [2:0] is [6];
    pv = '{3, 5, 7};
    ip = '{3'd4, 3'd3, 3'd1, 3'd7, 3'd0, 3'd6};
    is = '{3'd1, 3'd0, 3'd1, 3'd5, 3'd2, 3'd3};
`ifdef CLAUSE_SKIP_EN
    skip_zero = 1;
`else
    skip_zero = 0;
`endif

    repeat (3) tick();
    check_eq("reset_outs", ctl_outs(), 0);
    rst = 1'b0;
    tick();
    check_eq("idle_outs", ctl_outs(), 0);
    check_eq("idle_word", clause_write, 0);

    // Illegal configurations: fixed table, then random illegal picks.
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        patch_size = ip[i];
        stride     = is[i];
      end else begin
        do begin
          patch_size = 3'($urandom);
          stride     = 3'($urandom);
        end while ((patch_size == 3 || patch_size == 5 || patch_size == 7) &&
                   stride >= 1 && stride <= 4);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("cfg_err", {cfg_err, busy, mem_req}, 3'b100);
      tick();
      check_eq("cfg_err_end", {cfg_err, busy, mem_req}, 3'b000);
    end

    run_image(3, 1, 0, 10'b10_0000_0100, '0, -1, 0);
    run_image(7, 2, 2, 10'($urandom), '0, -1, 1);
    run_image(5, 3, 3, 10'($urandom), 10'b00_0000_1000, -1, 1);
    for (int n = 0; n < 4; n++) begin
      p = pv[$urandom_range(2, 0)];
      s = $urandom_range(4, 1);
      run_image(p, s, 3, 10'($urandom), (n % 2 == 0) ? 10'b00_0000_1000 : 10'($urandom & 32'h21), -1, 1);
    end

    // Reset during clause 5, then a fresh image must restart at clause 0.
    run_image(5, 1, 1, 10'($urandom), '0, 5, 0);
    check_eq("abort_hit", aborted, 1);
    tick();
    check_eq("rst_hold", ctl_outs(), 0);
    rst = 1'b0;
    tick();
    run_image(3, 2, 2, 10'($urandom), '0, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
